credit_sink: RTL and testbench

// - Receiving end of the Creditor credit loop: skid buffer at the exit of a credited section.
// - Absorbs every beat that the upstream Creditor lets through, with no backpressure on the input.
// - Forwards beats downstream under normal valid/ready.
// - Issues one credit_return pulse per beat that leaves the buffer, so in-flight beats never exceed buffer space.

---
 rtl/credit_sink.sv | 103 ++++++++++
 tb/tb_credit_sink.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/credit_sink.sv
// rtl/credit_sink.sv - exit skid buffer of a credited section; returns one credit per beat popped
// Optional feature macro: CREDIT_SINK_OVERFLOW_CHECK_EN (sticky overflow_err, in_ready tied high)
module credit_sink #(
  parameter int MAX_IN_TRANSIT = 8,
  parameter int DATA_W = 8,
  parameter int NUM_ELEMENTS = 4,
  localparam int OCC_W = $clog2(MAX_IN_TRANSIT + 1),
  localparam int PTR_W = (MAX_IN_TRANSIT > 1) ? $clog2(MAX_IN_TRANSIT) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_ELEMENTS*DATA_W-1:0] in_data,
  input  logic [NUM_ELEMENTS-1:0]        in_keep,
  input  logic                           in_last,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [NUM_ELEMENTS*DATA_W-1:0] out_data,
  output logic [NUM_ELEMENTS-1:0]        out_keep,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           credit_return,
  output logic [OCC_W-1:0]               occupancy
`ifdef CREDIT_SINK_OVERFLOW_CHECK_EN
  ,
  output logic                           overflow_err
`endif
);

  typedef struct packed {
    logic [NUM_ELEMENTS*DATA_W-1:0] data;
    logic [NUM_ELEMENTS-1:0]        keep;
    logic                           last;
  } entry_t;

  localparam logic [OCC_W-1:0] FULL     = OCC_W'(MAX_IN_TRANSIT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_IN_TRANSIT - 1);

  entry_t           mem [MAX_IN_TRANSIT];
  entry_t           head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             push;
  logic             pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (occupancy == FULL);
  assign out_valid = (occupancy != '0);
  assign pop       = out_valid && out_ready;
  // A pop frees the head slot in the same edge, so a full buffer can still accept.
  assign push      = in_valid && (!full || pop);

`ifdef CREDIT_SINK_OVERFLOW_CHECK_EN
  assign in_ready = 1'b1;
`else
  assign in_ready = !full || pop;
`endif

  assign head     = mem[rd_ptr];
  assign out_data = head.data;
  assign out_keep = head.keep;
  assign out_last = head.last;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{data: in_data, keep: in_keep, last: in_last};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      occupancy     <= '0;
      credit_return <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      credit_return <= pop;
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: ;
      endcase
    end
  end

`ifdef CREDIT_SINK_OVERFLOW_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_err <= 1'b0;
    end else if (in_valid && full && !pop) begin
      overflow_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_credit_sink.sv
// tb/tb_credit_sink.sv - scoreboard bench for credit_sink (depth 8 and depth 3 instances)
module tb_credit_sink;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data, out_data, b_in_data, b_out_data;
  logic [3:0]  in_keep, out_keep, b_in_keep, b_out_keep;
  logic        in_last, in_valid, in_ready, out_last, out_valid, out_ready, credit_return;
  logic        b_in_last, b_in_valid, b_in_ready, b_out_last, b_out_valid, b_out_ready, b_credit_return;
  logic [3:0]  occupancy;
  logic [1:0]  b_occupancy;
  logic        ovf, b_ovf;

  int n_cmp = 0;
  int n_fail = 0;
  logic [36:0] q[$];
  logic [36:0] q3[$];
  int credits;
  logic prev_pop, b_prev_pop;

  always #5 clk = ~clk;

  credit_sink #(.MAX_IN_TRANSIT(8), .DATA_W(8), .NUM_ELEMENTS(4)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .credit_return(credit_return), .occupancy(occupancy)
`ifdef CREDIT_SINK_OVERFLOW_CHECK_EN
    , .overflow_err(ovf)
`endif
  );

  credit_sink #(.MAX_IN_TRANSIT(3), .DATA_W(8), .NUM_ELEMENTS(4)) dut3 (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_keep(b_in_keep), .in_last(b_in_last), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_keep(b_out_keep), .out_last(b_out_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .credit_return(b_credit_return), .occupancy(b_occupancy)
`ifdef CREDIT_SINK_OVERFLOW_CHECK_EN
    , .overflow_err(b_ovf)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic l);
    in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
    q.push_back({d, k, l});
  endtask

  task automatic drive3(input logic [31:0] d);
    b_in_valid = 1'b1; b_in_data = d; b_in_keep = 4'hF; b_in_last = 1'b0;
    q3.push_back({d, 4'hF, 1'b0});
  endtask

  // Paired-Creditor model: a returned credit is usable in the cycle it arrives.
  always @(posedge clk or posedge rst) begin
    if (rst) credits <= 8;
    else credits <= credits - int'(in_valid && in_ready) + int'(credit_return);
  end

  // Output monitors: drivers change inputs on negedge, so sampling 1ns later sees settled handshakes.
  always begin
    @(negedge clk); #1;
    if (rst) begin
      prev_pop = 1'b0;
    end else begin
      check("credit_return_d8", credit_return, prev_pop);
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("unexpected_beat_d8", 1, 0);
        else check("beat_d8", {out_data, out_keep, out_last}, q.pop_front());
      end
      prev_pop = out_valid && out_ready;
    end
  end

  always begin
    @(negedge clk); #1;
    if (rst) begin
      b_prev_pop = 1'b0;
    end else begin
      check("credit_return_d3", b_credit_return, b_prev_pop);
      if (b_out_valid && b_out_ready) begin
        if (q3.size() == 0) check("unexpected_beat_d3", 1, 0);
        else check("beat_d3", {b_out_data, b_out_keep, b_out_last}, q3.pop_front());
      end
      b_prev_pop = b_out_valid && b_out_ready;
    end
  end

  initial begin
    int cnt;
    int sent;
    int cycles;
    rst = 1'b1;
    in_valid = 0; in_data = 0; in_keep = 0; in_last = 0; out_ready = 0;
    b_in_valid = 0; b_in_data = 0; b_in_keep = 0; b_in_last = 0; b_out_ready = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_credit", credit_return, 0);
    check("rst_occ", occupancy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_occ_d3", b_occupancy, 0);
`ifdef CREDIT_SINK_OVERFLOW_CHECK_EN
    check("rst_ovf", ovf, 0);
`endif

    // Fill depth 8 with no drain, then drain and count the credit burst.
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(32'(i), 4'hF, 1'b0);
      @(negedge clk);
    end
    in_valid = 0; #1;
    check("full_occ", occupancy, 8);
    check("full_valid", out_valid, 1);
`ifndef CREDIT_SINK_OVERFLOW_CHECK_EN
    check("full_in_ready", in_ready, 0);
`endif
    @(negedge clk);
    out_ready = 1; cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (credit_return) cnt++;
    end
    check("credit_burst_len", cnt, 8);
    check("drained_occ", occupancy, 0);
    out_ready = 0;

    // last/keep carried through and held while stalled.
    @(negedge clk);
    drive(32'hDEADBEEF, 4'b0011, 1'b1);
    @(negedge clk);
    in_valid = 0;
    for (int k = 0; k < 5; k++) begin
      #1 check("stall_hold", {out_valid, out_data, out_keep, out_last}, {1'b1, 32'hDEADBEEF, 4'b0011, 1'b1});
      @(negedge clk);
    end
    out_ready = 1;
    repeat (2) @(negedge clk);
    out_ready = 0;

    // Random drain against the Creditor model.
    sent = 0; cycles = 0;
    while ((sent < 1000 || q.size() > 0) && cycles < 20000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 1000 && (credits > 0 || credit_return) && $urandom_range(0, 3) != 0) begin
        drive(32'(sent * 32'h01010101), 4'(sent), (sent % 7) == 6);
        sent++;
      end else begin
        in_valid = 0;
      end
      #1;
      if (in_valid && !in_ready) check("credited_in_ready", in_ready, 1);
      if (occupancy > 8) check("occ_bound", occupancy, 8);
      @(negedge clk);
      cycles++;
    end
    in_valid = 0; out_ready = 0;
    check("random_timeout", cycles < 20000, 1);
    repeat (2) @(negedge clk);
    #1;
    check("idle_credits", credits, 8);
    check("idle_occ", occupancy, 0);

    // Reset with 5 beats held drops them without returning credits.
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      drive(32'h100 + 32'(i), 4'hF, 1'b0);
      @(negedge clk);
    end
    in_valid = 0; #1;
    check("pre_rst_occ", occupancy, 5);
    @(negedge clk); #2;
    rst = 1'b1; #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_occ", occupancy, 0);
    q.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      if (credit_return) cnt++;
    end
    check("post_rst_credits", cnt, 0);

    // Depth 3: hold full with simultaneous push and pop across several wraps.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive3(32'h300 + 32'(i));
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++) begin
      drive3(32'h303 + 32'(k));
      b_out_ready = 1; #1;
      check("d3_occ", b_occupancy, 3);
      check("d3_in_ready", b_in_ready, 1);
      check("d3_credit", b_credit_return, k > 0);
      @(negedge clk);
    end
    b_in_valid = 0;
    repeat (6) @(negedge clk);
    #1 check("d3_drained", b_occupancy, 0);
    check("d3_queue_empty", q3.size(), 0);
    b_out_ready = 0;

`ifdef CREDIT_SINK_OVERFLOW_CHECK_EN
    // A 9th beat into a full buffer sets the sticky flag and is discarded.
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(32'h200 + 32'(i), 4'hF, 1'b0);
      @(negedge clk);
    end
    in_valid = 1; in_data = 32'hBAD0BAD0; in_keep = 4'h1; in_last = 1; #1;
    check("ovf_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0; #1;
    check("ovf_set", ovf, 1);
    check("ovf_occ", occupancy, 8);
    @(negedge clk);
    out_ready = 1;
    repeat (12) @(negedge clk);
    out_ready = 0; #1;
    check("ovf_sticky", ovf, 1);
    check("ovf_queue_empty", q.size(), 0);
`endif

    repeat (2) @(negedge clk);
    check("final_queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
